// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner
//   Master-side input conditioning for the I2C repeater. Raw SCL/SDA are
//   synchronised into system_clk, glitch-filtered, and decoded into
//   START/STOP events and the bit/ACK position of each 9-bit frame.
//
// Ports
//   system_clk  : system clock, rising edge
//   reset       : synchronous, active-high
//   scl_in      : raw master SCL (asynchronous)
//   sda_in      : raw master SDA (asynchronous)
//   scl_filt    : synchronised, filtered SCL
//   sda_filt    : synchronised, filtered SDA
//   scl_rise    : one-cycle pulse, scl_filt 0->1
//   scl_fall    : one-cycle pulse, scl_filt 1->0
//   start_det   : one-cycle pulse on START / repeated START
//   stop_det    : one-cycle pulse on STOP
//   bus_busy    : high between START and STOP
//   bit_cnt     : 0..7 data bit, 8 ACK bit
//   ack_phase   : high while the frame is in its ACK bit
//   ack_done    : one-cycle pulse at the SCL fall ending the ACK bit
//   ack_nack    : SDA sampled at the ACK-bit SCL rise (0 = ACK)
module i2c_bus_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_filt,
  output logic       sda_filt,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic [3:0] bit_cnt,
  output logic       ack_phase,
  output logic       ack_done,
  output logic       ack_nack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START_HOLD,
    S_DATA,
    S_ACK
  } state_t;

  localparam logic [CNT_W-1:0] FILT_TERM = CNT_W'(FILTER_LEN - 1);

  // Synchronisers
  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_sync;
  logic                   sda_sync;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_sync = scl_sync_q[SYNC_STAGES-1];
  assign sda_sync = sda_sync_q[SYNC_STAGES-1];

  // Stability filters
  logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d;
  logic [CNT_W-1:0] sda_cnt_q, sda_cnt_d;
  logic             scl_filt_q, scl_filt_d;
  logic             sda_filt_q, sda_filt_d;
  logic             scl_prev_q;
  logic             sda_prev_q;

  always_comb begin
    scl_cnt_d  = scl_cnt_q;
    scl_filt_d = scl_filt_q;
    if (scl_sync == scl_filt_q) begin
      scl_cnt_d = '0;
    end else if (scl_cnt_q == FILT_TERM) begin
      scl_filt_d = scl_sync;
      scl_cnt_d  = '0;
    end else begin
      scl_cnt_d = scl_cnt_q + 1'b1;
    end
  end

  always_comb begin
    sda_cnt_d  = sda_cnt_q;
    sda_filt_d = sda_filt_q;
    if (sda_sync == sda_filt_q) begin
      sda_cnt_d = '0;
    end else if (sda_cnt_q == FILT_TERM) begin
      sda_filt_d = sda_sync;
      sda_cnt_d  = '0;
    end else begin
      sda_cnt_d = sda_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
    end
  end

  // Edge and bus-condition decode (registers only, no raw-input paths)
  logic sda_rise_int;
  logic sda_fall_int;
  logic scl_stable_hi;

  assign scl_rise      = scl_filt_q & ~scl_prev_q;
  assign scl_fall      = ~scl_filt_q & scl_prev_q;
  assign sda_rise_int  = sda_filt_q & ~sda_prev_q;
  assign sda_fall_int  = ~sda_filt_q & sda_prev_q;
  // SCL must be high on both sides of the SDA edge, so simultaneous
  // SCL/SDA changes never qualify.
  assign scl_stable_hi = scl_filt_q & scl_prev_q;
  assign start_det     = sda_fall_int & scl_stable_hi;
  assign stop_det      = sda_rise_int & scl_stable_hi;

  // Frame tracker
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = S_START_HOLD;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        S_START_HOLD: begin
          // This fall completes the START and is not a data bit.
          if (scl_fall) begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        S_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d   = S_ACK;
              bit_cnt_d = 4'd8;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_ACK: begin
          if (scl_rise) begin
            nack_d = sda_filt_q;
          end
          if (scl_fall) begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      busy_q    <= 1'b0;
      nack_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
    end
  end

  assign scl_filt  = scl_filt_q;
  assign sda_filt  = sda_filt_q;
  assign bus_busy  = busy_q;
  assign bit_cnt   = bit_cnt_q;
  assign ack_phase = (state_q == S_ACK);
  assign ack_nack  = nack_q;
  assign ack_done  = (state_q == S_ACK) & scl_fall & ~start_det & ~stop_det;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// Testbench for i2c_bus_conditioner: directed I2C bus vectors with
// hand-derived expectations, plus hand-written filter/reset sequences.
module tb_i2c_bus_conditioner;

  logic       system_clk = 1'b0;
  logic       reset;
  logic       scl_in;
  logic       sda_in;
  logic       scl_filt;
  logic       sda_filt;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       bus_busy;
  logic [3:0] bit_cnt;
  logic       ack_phase;
  logic       ack_done;
  logic       ack_nack;

  i2c_bus_conditioner #(
    .SYNC_STAGES(2),
    .FILTER_LEN (3),
    .CNT_W      (4)
  ) dut (
    .system_clk(system_clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_filt  (scl_filt),
    .sda_filt  (sda_filt),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .bit_cnt   (bit_cnt),
    .ack_phase (ack_phase),
    .ack_done  (ack_done),
    .ack_nack  (ack_nack)
  );

  always #5 system_clk = ~system_clk;

  typedef struct {
    logic        scl;
    logic        sda;
    logic [3:0]  exp_cnt;
    logic        exp_ack;
    logic        exp_busy;
    logic        exp_nack;
    int unsigned exp_start;
    int unsigned exp_stop;
    int unsigned exp_ackdone;
  } vec_t;

  vec_t        vecs[$];
  logic        m_nack;
  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned c_start, c_stop, c_rise, c_fall, c_ackdone;

  task automatic clr_counts();
    c_start   = 0;
    c_stop    = 0;
    c_rise    = 0;
    c_fall    = 0;
    c_ackdone = 0;
  endtask

  // Advance n cycles, sampling on the falling edge and tallying pulses.
  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge system_clk);
      c_start   += {31'd0, start_det};
      c_stop    += {31'd0, stop_det};
      c_rise    += {31'd0, scl_rise};
      c_fall    += {31'd0, scl_fall};
      c_ackdone += {31'd0, ack_done};
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic scl, input logic sda, input logic [3:0] cnt,
                     input logic ack, input logic busy,
                     input int unsigned st, input int unsigned sp, input int unsigned ad);
    vec_t v;
    v.scl = scl; v.sda = sda; v.exp_cnt = cnt; v.exp_ack = ack; v.exp_busy = busy;
    v.exp_nack = m_nack; v.exp_start = st; v.exp_stop = sp; v.exp_ackdone = ad;
    vecs.push_back(v);
  endtask

  // n data bits MSB first: set SDA with SCL low, raise SCL, drop SCL.
  task automatic add_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      add(1'b0, b[7-i], 4'(i), 1'b0, 1'b1, 0, 0, 0);
      add(1'b1, b[7-i], 4'(i), 1'b0, 1'b1, 0, 0, 0);
      if (i == 7) add(1'b0, b[7-i], 4'd8, 1'b1, 1'b1, 0, 0, 0);
      else        add(1'b0, b[7-i], 4'(i + 1), 1'b0, 1'b1, 0, 0, 0);
    end
  endtask

  task automatic add_byte(input logic [7:0] b, input logic ackbit);
    add_bits(b, 8);
    add(1'b0, ackbit, 4'd8, 1'b1, 1'b1, 0, 0, 0);
    m_nack = ackbit;
    add(1'b1, ackbit, 4'd8, 1'b1, 1'b1, 0, 0, 0);
    add(1'b0, ackbit, 4'd0, 1'b0, 1'b1, 0, 0, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_counts();

    // Vector table: each row is applied and left to settle for 6 cycles.
    m_nack = 1'b1;
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1, 0, 0);  // START
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 0);  // START-owned fall, not counted
    add_byte(8'hA0, 1'b0);                        // slave ACK
    add_byte(8'h3C, 1'b1);                        // slave NACK
    add_bits(8'hA5, 3);                           // stop mid-byte at bit 3
    add(1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 0, 0, 0);
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1, 0, 0);  // repeated START
    add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 0);  // not counted
    add(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 0, 0, 0);
    add(1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 0, 0, 0);  // counted
    add(1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 0, 0, 0);
    add(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 1, 0);  // STOP
    add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0, 0);  // IDLE ignores SCL
    add(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0, 0);
    add(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0, 0);
    add(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 0, 0, 0);

    // Reset with both lines low
    reset  = 1'b1;
    scl_in = 1'b0;
    sda_in = 1'b0;
    @(negedge system_clk);
    chk1("rst scl_filt", scl_filt, 1'b1);
    chk1("rst sda_filt", sda_filt, 1'b1);
    chk1("rst bus_busy", bus_busy, 1'b0);
    chkn("rst bit_cnt", 32'(bit_cnt), 0);
    chk1("rst ack_nack", ack_nack, 1'b1);
    chk1("rst ack_phase", ack_phase, 1'b0);
    @(negedge system_clk);
    reset = 1'b0;
    clr_counts();
    step(4);
    chk1("post-rst scl_filt held", scl_filt, 1'b1);
    chk1("post-rst sda_filt held", sda_filt, 1'b1);
    step(1);
    chk1("post-rst scl_filt fell", scl_filt, 1'b0);
    chk1("post-rst sda_filt fell", sda_filt, 1'b0);
    chkn("post-rst scl_fall count", c_fall, 1);
    step(3);
    chkn("post-rst start count", c_start, 0);

    // Bring bus idle (both rise together: no STOP)
    clr_counts();
    scl_in = 1'b1;
    sda_in = 1'b1;
    step(6);
    chk1("idle scl_filt", scl_filt, 1'b1);
    chk1("idle sda_filt", sda_filt, 1'b1);
    chkn("idle stop count", c_stop, 0);
    chk1("idle bus_busy", bus_busy, 1'b0);

    // 2-cycle SCL glitch must be rejected
    clr_counts();
    scl_in = 1'b0;
    step(2);
    scl_in = 1'b1;
    step(6);
    chk1("glitch2 scl_filt", scl_filt, 1'b1);
    chkn("glitch2 scl_fall count", c_fall, 0);

    // 3-cycle low passes, visible after edge 4 with a single-cycle fall pulse
    clr_counts();
    scl_in = 1'b0;
    step(3);
    scl_in = 1'b1;
    step(1);
    chk1("low3 scl_filt before", scl_filt, 1'b1);
    step(1);
    chk1("low3 scl_filt after edge4", scl_filt, 1'b0);
    chk1("low3 scl_fall pulse", scl_fall, 1'b1);
    step(1);
    chk1("low3 scl_fall single", scl_fall, 1'b0);
    step(4);
    chk1("low3 scl_filt recovered", scl_filt, 1'b1);
    chkn("low3 scl_fall count", c_fall, 1);
    chkn("low3 scl_rise count", c_rise, 1);
    chkn("low3 start count", c_start, 0);

    // Table-driven frame sequence
    foreach (vecs[r]) begin
      vec_t v;
      v = vecs[r];
      clr_counts();
      scl_in = v.scl;
      sda_in = v.sda;
      step(6);
      chkn($sformatf("row%0d bit_cnt", r), 32'(bit_cnt), 32'(v.exp_cnt));
      chk1($sformatf("row%0d ack_phase", r), ack_phase, v.exp_ack);
      chk1($sformatf("row%0d bus_busy", r), bus_busy, v.exp_busy);
      chk1($sformatf("row%0d ack_nack", r), ack_nack, v.exp_nack);
      chkn($sformatf("row%0d start_det", r), c_start, v.exp_start);
      chkn($sformatf("row%0d stop_det", r), c_stop, v.exp_stop);
      chkn($sformatf("row%0d ack_done", r), c_ackdone, v.exp_ackdone);
    end

    // SCL and SDA falling together: no START
    clr_counts();
    scl_in = 1'b0;
    sda_in = 1'b0;
    step(6);
    chkn("sim-fall start count", c_start, 0);
    chkn("sim-fall scl_fall count", c_fall, 1);
    chk1("sim-fall bus_busy", bus_busy, 1'b0);
    clr_counts();
    scl_in = 1'b1;
    sda_in = 1'b1;
    step(6);
    chkn("sim-rise stop count", c_stop, 0);

    // Reset mid-frame at bit_cnt = 5
    sda_in = 1'b0;
    step(6);
    scl_in = 1'b0;
    step(6);
    for (int unsigned i = 0; i < 5; i++) begin
      scl_in = 1'b1;
      step(6);
      scl_in = 1'b0;
      step(6);
    end
    chkn("pre-rst bit_cnt", 32'(bit_cnt), 5);
    chk1("pre-rst bus_busy", bus_busy, 1'b1);
    clr_counts();
    reset  = 1'b1;
    sda_in = 1'b1;
    step(2);
    chkn("mid-rst bit_cnt", 32'(bit_cnt), 0);
    chk1("mid-rst bus_busy", bus_busy, 1'b0);
    chk1("mid-rst scl_filt", scl_filt, 1'b1);
    reset = 1'b0;
    step(8);
    chkn("mid-rst stop count", c_stop, 0);
    chkn("mid-rst start count", c_start, 0);
    chk1("after-rst bus_busy", bus_busy, 1'b0);
    chkn("after-rst bit_cnt", 32'(bit_cnt), 0);
    chk1("after-rst scl_filt", scl_filt, 1'b0);
    chk1("after-rst ack_phase", ack_phase, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_bus_conditioner.md
Name: i2c_bus_conditioner

Overview:
Input-side conditioning stage placed directly upstream of the I2C repeater on the master-facing bus. It synchronises raw master SCL/SDA into system_clk and removes glitches with a stability filter. It then detects START/STOP and tracks the bit/ACK position of each 9-bit frame. The repeater consumes the clean levels and the ack_phase flag to decide SDA direction.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line (min 2).
FILTER_LEN, 3, consecutive differing synchronised samples required before a filtered line changes (min 1).
CNT_W, 4, width of the internal filter counters; must hold FILTER_LEN.

Ports:
system_clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
scl_in  in  1  raw master SCL (asynchronous)
sda_in  in  1  raw master SDA input value (asynchronous)
scl_filt  out  1  synchronised, filtered SCL
sda_filt  out  1  synchronised, filtered SDA
scl_rise  out  1  one-cycle pulse on scl_filt 0->1
scl_fall  out  1  one-cycle pulse on scl_filt 1->0
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
bus_busy  out  1  high between START and STOP
bit_cnt  out  4  bit position in current frame, 0..7 data, 8 ACK
ack_phase  out  1  high while the frame is in its ACK bit
ack_done  out  1  one-cycle pulse at the SCL fall ending the ACK bit
ack_nack  out  1  SDA sampled at the ACK-bit SCL rise (0 = ACK)

Behaviour:
- Reset (synchronous, wins over everything): sync flops and scl_filt/sda_filt = 1; filter counters = 0; all pulses = 0; bus_busy = 0; bit_cnt = 0; ack_phase = 0; ack_nack = 1; state = IDLE. Reset mid-frame aborts the frame and emits no stop_det.
- Synchroniser: SYNC_STAGES flop chain per line.
- Filter, per line:
  - If the sync output equals filt, the counter clears.
  - Otherwise the counter increments. On the FILTER_LEN-th consecutive differing edge, filt takes the sync value and the counter clears.
  - Latency: the first edge sampling the new raw value is edge 0. filt shows the new value after edge SYNC_STAGES+FILTER_LEN-1 (defaults: edge 4).
  - A pulse shorter than FILTER_LEN sync samples never reaches filt.
- Edge pulses: scl_rise = scl_filt & ~scl_filt_d; scl_fall = ~scl_filt & scl_filt_d. Each is high exactly in the first cycle filt shows the new value.
- SDA edges are internal only.
- START = SDA fall with scl_filt==1 and scl_filt_d==1. STOP = SDA rise under the same SCL condition.
- If SCL and SDA change in the same cycle, no START or STOP is detected.
- State machine (IDLE, START_HOLD, DATA, ACK):
  - Any state, stop_det: -> IDLE, bit_cnt = 0, bus_busy = 0.
  - Any state, start_det: -> START_HOLD, bit_cnt = 0, bus_busy = 1. A repeated START keeps bus_busy high.
  - START_HOLD, scl_fall: -> DATA, bit_cnt = 0. This fall belongs to the START and is not counted.
  - DATA, scl_fall: bit_cnt + 1. On the fall with bit_cnt==7: -> ACK, bit_cnt = 8.
  - ACK, scl_rise: ack_nack <= sda_filt.
  - ACK, scl_fall: -> DATA, bit_cnt = 0, ack_done pulse.
  - IDLE ignores SCL edges.
- ack_phase = (state==ACK). All outputs are registered or decoded from registers; no raw-input-to-output combinational path.
- start_det/stop_det take priority over SCL edge handling in the same cycle.

Test Plan:
1. Assert reset 2 cycles with scl_in=sda_in=0 held. During reset, filt=1, bus_busy=0, bit_cnt=0, ack_nack=1. After release, scl_filt and sda_filt fall together 4 cycles later, with no start_det.
2. Defaults, bus idle: scl_in low for 2 cycles -> scl_filt stays 1, no scl_fall. scl_in low for 3 cycles -> scl_filt=0 after edge 4, single-cycle scl_fall.
3. SCL high, SDA falls, SCL falls later -> one start_det pulse, bus_busy=1. The first scl_fall leaves bit_cnt=0 and enters DATA.
4. Byte 0xA0 followed by slave ACK (SDA=0 on 9th clock):
   - bit_cnt steps 1..7 on successive falls, then 8 with ack_phase=1.
   - ack_nack=0 at the 9th rise.
   - The 9th fall gives ack_done one cycle, bit_cnt=0, ack_phase=0.
   - Repeat with SDA=1 -> ack_nack=1.
5. Mid-byte at bit_cnt=3, repeated START -> start_det, bit_cnt=0, state START_HOLD, bus_busy stays 1. Then a STOP -> stop_det, bus_busy=0, IDLE.
6. SCL and SDA falling on the same cycle -> no start_det. Reset asserted at bit_cnt=5 -> IDLE, bit_cnt=0, bus_busy=0, no stop_det.
